// File: rtl/pico9_uart.sv
// rtl/pico9_uart.sv - pico9 I/O-bus UART with 4-deep TX/RX FIFOs, 8N1 framing
module pico9_uart #(
    parameter int         FIFO_AW  = 2,
    parameter logic [8:0] DIV_INIT = 9'd103
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] port,
    input  logic       iord,
    input  logic       iowr,
    input  logic [8:0] data_out,
    output logic [8:0] data_in,
    output logic       txd,
    input  logic       rxd
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    logic [8:0]       div_q;
    logic [7:0]       tx_mem_q [DEPTH];
    logic [7:0]       rx_mem_q [DEPTH];
    logic [FIFO_AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic             tx_ovf_q, frame_err_q, rx_ovr_q;
    logic             tx_ovf_d, frame_err_d, rx_ovr_d;
    tx_state_t        tx_st_q;
    logic [8:0]       tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_sh_q;
    logic             txd_q;
    rx_state_t        rx_st_q;
    logic [8:0]       rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_sh_q;
    logic [1:0]       sync_q;

    // Divisor values below 3 are kept as written but timed as 3
    logic [8:0] div_eff;
    assign div_eff = (div_q < 9'd3) ? 9'd3 : div_q;

    logic rx_s;
    assign rx_s = sync_q[1];

    logic tx_empty, tx_full, rx_empty, rx_full, tx_idle;
    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[FIFO_AW] != tx_rp_q[FIFO_AW]) &&
                      (tx_wp_q[FIFO_AW-1:0] == tx_rp_q[FIFO_AW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[FIFO_AW] != rx_rp_q[FIFO_AW]) &&
                      (rx_wp_q[FIFO_AW-1:0] == rx_rp_q[FIFO_AW-1:0]);
    assign tx_idle  = tx_empty && (tx_st_q == TX_IDLE);

    // The engine reloads from IDLE or straight out of the last stop-bit clock (no gap)
    logic tx_pop, tx_push_req, tx_push, rx_pop, rx_push_req, rx_push, frame_set, flag_clr;
    assign tx_pop      = !tx_empty && ((tx_st_q == TX_IDLE) ||
                                       (tx_st_q == TX_STOP && tx_cnt_q == 9'd0));
    assign tx_push_req = iowr && (port == 3'd0);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign rx_pop      = iord && (port == 3'd0) && !rx_empty;
    assign rx_push_req = (rx_st_q == RX_STOP) && (rx_cnt_q == 9'd0) && rx_s;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign frame_set   = (rx_st_q == RX_STOP) && (rx_cnt_q == 9'd0) && !rx_s;
    assign flag_clr    = iowr && (port == 3'd1);

    // Sticky flags: a set in the same cycle as a clear wins
    assign tx_ovf_d    = (tx_ovf_q    & ~(flag_clr & data_out[6])) | (tx_push_req & ~tx_push);
    assign frame_err_d = (frame_err_q & ~(flag_clr & data_out[5])) | frame_set;
    assign rx_ovr_d    = (rx_ovr_q    & ~(flag_clr & data_out[4])) | (rx_push_req & ~rx_push);

    // Zero-latency read mux; port 0 pop happens at the closing edge
    always_comb begin
        data_in = 9'h000;
        if (iord && reset) begin
            case (port)
                3'd0:    data_in = rx_empty ? 9'h100 : {1'b0, rx_mem_q[rx_rp_q[FIFO_AW-1:0]]};
                3'd1:    data_in = {2'b00, tx_ovf_q, frame_err_q, rx_ovr_q,
                                    tx_idle, tx_full, rx_full, rx_empty};
                3'd2:    data_in = div_q;
                default: data_in = 9'h000;
            endcase
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q[FIFO_AW-1:0]] <= data_out[7:0];
        if (rx_push) rx_mem_q[rx_wp_q[FIFO_AW-1:0]] <= rx_sh_q;
    end

    // Pointers, divisor, sticky flags and the rxd synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            div_q       <= DIV_INIT;
            tx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_ovr_q    <= 1'b0;
            sync_q      <= 2'b11;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            if (iowr && port == 3'd2) div_q <= data_out;
            tx_ovf_q    <= tx_ovf_d;
            frame_err_q <= frame_err_d;
            rx_ovr_q    <= rx_ovr_d;
            sync_q      <= {sync_q[0], rxd};
        end
    end

    // TX engine: start, 8 data bits LSB first, stop; txd is a registered output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= 9'd0;
            tx_bit_q <= 3'd0;
            tx_sh_q  <= 8'd0;
            txd_q    <= 1'b1;
        end else begin
            case (tx_st_q)
                TX_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_pop) begin
                        tx_sh_q  <= tx_mem_q[tx_rp_q[FIFO_AW-1:0]];
                        tx_cnt_q <= div_eff;
                        txd_q    <= 1'b0;
                        tx_st_q  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == 9'd0) begin
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                        tx_cnt_q <= div_eff;
                        tx_bit_q <= 3'd0;
                        tx_st_q  <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 9'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == 9'd0) begin
                        tx_cnt_q <= div_eff;
                        if (tx_bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            tx_st_q <= TX_STOP;
                        end else begin
                            txd_q    <= tx_sh_q[0];
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            tx_bit_q <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 9'd1;
                    end
                end
                default: begin
                    if (tx_cnt_q == 9'd0) begin
                        if (tx_pop) begin
                            tx_sh_q  <= tx_mem_q[tx_rp_q[FIFO_AW-1:0]];
                            tx_cnt_q <= div_eff;
                            txd_q    <= 1'b0;
                            tx_st_q  <= TX_START;
                        end else begin
                            tx_st_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 9'd1;
                    end
                end
            endcase
        end
    end

    assign txd = txd_q;

    // RX engine: half-bit start qualify, mid-bit sampling, break wait after a bad stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st_q  <= RX_IDLE;
            rx_cnt_q <= 9'd0;
            rx_bit_q <= 3'd0;
            rx_sh_q  <= 8'd0;
        end else begin
            case (rx_st_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt_q <= {1'b0, div_eff[8:1]} - 9'd1;
                        rx_st_q  <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == 9'd0) begin
                        rx_cnt_q <= div_eff;
                        rx_bit_q <= 3'd0;
                        rx_st_q  <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 9'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == 9'd0) begin
                        rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
                        rx_cnt_q <= div_eff;
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 9'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == 9'd0) begin
                        rx_st_q <= rx_s ? RX_IDLE : RX_BREAK;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 9'd1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) rx_st_q <= RX_IDLE;
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pico9_uart.sv
// tb/tb_pico9_uart.sv - scoreboard bench for pico9_uart
module tb_pico9_uart;
    logic       clk = 1'b0;
    logic       reset, iord, iowr, rxd;
    logic [2:0] port;
    logic [8:0] data_out, data_in;
    logic       txd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    bit         tx_mon_en = 1'b0;
    int         last_fall = -1;

    pico9_uart dut (
        .clk      (clk),
        .reset    (reset),
        .port     (port),
        .iord     (iord),
        .iowr     (iowr),
        .data_out (data_out),
        .data_in  (data_in),
        .txd      (txd),
        .rxd      (rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic io_read(input logic [2:0] p, output logic [8:0] v);
        port = p;
        iord = 1'b1;
        @(negedge clk);
        v = data_in;
        @(posedge clk);
        #1;
        iord = 1'b0;
    endtask

    task automatic io_write(input logic [2:0] p, input logic [8:0] d);
        port     = p;
        data_out = d;
        iowr     = 1'b1;
        @(posedge clk);
        #1;
        iowr = 1'b0;
    endtask

    task automatic rd_check(input logic [2:0] p, input logic [8:0] exp, input string tag);
        logic [8:0] v;
        io_read(p, v);
        check(tag, v, exp);
    endtask

    task automatic drain(input string tag);
        logic [8:0] v;
        logic [8:0] exp;
        for (int i = 0; i < 5; i++) begin
            exp = (rxq.size() != 0) ? {1'b0, rxq.pop_front()} : 9'h100;
            io_read(3'd0, v);
            check(tag, v, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input bit exp_push);
        if (exp_push) rxq.push_back(b);
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (4) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Serial TX decoder at 4 clocks/bit, sampling on falling clock edges
    always begin
        logic [7:0] b;
        int         t;
        @(negedge txd);
        if (tx_mon_en) begin
            t = cyc;
            if (last_fall >= 0) check("tx_gap", 9'(t - last_fall), 9'd40);
            last_fall = t;
            repeat (2) @(negedge clk);
            check("tx_start", {8'd0, txd}, 9'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = txd;
            end
            repeat (4) @(negedge clk);
            check("tx_stop", {8'd0, txd}, 9'd1);
            check("tx_byte", {1'b0, b}, (txq.size() != 0) ? {1'b0, txq.pop_front()} : 9'h1FF);
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] v;
        logic       exp_b;
        logic [7:0] tb_byte;
        logic [7:0] r2 [5];
        r2 = '{8'h3C, 8'hF0, 8'h0F, 8'h81, 8'hA3};

        reset = 1'b0; iord = 1'b0; iowr = 1'b0; port = 3'd0; data_out = 9'd0; rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        rd_check(3'd1, 9'h009, "rst_status");
        rd_check(3'd2, 9'd103, "rst_div");
        rd_check(3'd0, 9'h100, "rst_rx");
        check("rst_txd", {8'd0, txd}, 9'd1);
        rd_check(3'd3, 9'h000, "port3");

        io_write(3'd2, 9'd3);
        rd_check(3'd2, 9'd3, "div_wr");

        // Exact waveform of one 0x5A frame at 4 clocks per bit
        tb_byte = 8'h5A;
        io_write(3'd0, {1'b0, tb_byte});
        check("tx_pre", {8'd0, txd}, 9'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       exp_b = 1'b0;
            else if (k >= 36) exp_b = 1'b1;
            else             exp_b = tb_byte[(k - 4) / 4];
            check($sformatf("tx_bit%0d", k), {8'd0, txd}, {8'd0, exp_b});
            @(posedge clk);
            #1;
        end
        rd_check(3'd1, 9'h009, "tx_idle_back");

        // Six back-to-back writes: five frames, sixth dropped
        tx_mon_en = 1'b1;
        last_fall = -1;
        for (int i = 0; i < 6; i++) begin
            tb_byte = 8'(8'h11 * (i + 1));
            if (i < 5) txq.push_back(tb_byte);
            io_write(3'd0, {1'b0, tb_byte});
        end
        rd_check(3'd1, 9'h045, "tx_ovf_set");
        io_write(3'd1, 9'h040);
        rd_check(3'd1, 9'h005, "tx_ovf_clr");
        for (int i = 0; i < 400 && txq.size() != 0; i++) @(posedge clk);
        #1;
        check("tx_drain", 9'(txq.size()), 9'd0);
        tx_mon_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rd_check(3'd1, 9'h009, "tx_done");

        // RX overrun on the fifth frame
        for (int i = 0; i < 5; i++) begin
            send_rx(8'hA3, 1'b1, i < 4);
            if (i == 3) rd_check(3'd1, 9'h00A, "rx_full");
        end
        rd_check(3'd1, 9'h01A, "rx_ovr_set");
        drain("rx1_data");
        io_write(3'd1, 9'h010);
        rd_check(3'd1, 9'h009, "rx_ovr_clr");

        // Pop on the same edge as the fifth push: no overrun
        for (int i = 0; i < 4; i++) send_rx(r2[i], 1'b1, 1'b1);
        fork
            send_rx(r2[4], 1'b1, 1'b1);
            begin
                logic [8:0] pv;
                repeat (39) @(posedge clk);
                #1;
                io_read(3'd0, pv);
                check("rx_pop_push", pv, {1'b0, rxq.pop_front()});
            end
        join
        rd_check(3'd1, 9'h00A, "rx_no_ovr");
        drain("rx2_data");

        // Bad stop bit, then a held break
        send_rx(8'h55, 1'b0, 1'b0);
        rd_check(3'd1, 9'h029, "frame_err_brk");
        repeat (19) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        rd_check(3'd1, 9'h029, "frame_err");
        rd_check(3'd0, 9'h100, "frame_nopush");
        io_write(3'd1, 9'h020);
        rd_check(3'd1, 9'h009, "frame_clr");

        // One-clock glitch
        rxd = 1'b0;
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        rd_check(3'd1, 9'h009, "glitch_flags");
        rd_check(3'd0, 9'h100, "glitch_rx");

        // Reset in the middle of TX and RX frames
        rxd = 1'b0;
        io_write(3'd0, 9'h000);
        io_write(3'd0, 9'h000);
        repeat (10) @(posedge clk);
        #1;
        check("mid_txd", {8'd0, txd}, 9'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_async_txd", {8'd0, txd}, 9'd1);
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        rd_check(3'd1, 9'h009, "post_rst_status");
        rd_check(3'd2, 9'd103, "post_rst_div");
        rd_check(3'd0, 9'h100, "post_rst_rx");
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_txd", {8'd0, txd}, 9'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pico9_uart.md
# pico9_uart

Byte-wide UART peripheral answering the pico9 CPU I/O bus: the responder end of the CPU's `port`/`iord`/`iowr`/`data_in`/`data_out` interface. It holds a 4-entry TX FIFO and a 4-entry RX FIFO, a programmable bit divisor, and sticky error flags. It serialises 8N1 frames on `txd` and deserialises them from `rxd`. It is instantiated beside the CPU, with bus signals connected by name.

## Interface
- `FIFO_AW`, 2, log2 of depth for each FIFO (depth 4)
- `DIV_INIT`, 9'd103, reset value of the bit divisor D; bit period is D+1 clocks
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `port`  in  3  register select from CPU
- `iord`  in  1  one-cycle read strobe; read data is consumed by the CPU at the same edge
- `iowr`  in  1  one-cycle write strobe
- `data_out`  in  9  CPU write data
- `data_in`  out  9  read data to CPU; combinational from `port`/state while `iord`=1, else 9'h000
- `txd`  out  1  serial out, idle high
- `rxd`  in  1  serial in, asynchronous to `clk`

## Operation
- Read map (`iord`):
  - port 0 = RX data {rx_empty, byte}. When non-empty, returns {0, head} and pops at that edge. When empty, returns 9'h100 with no pop.
  - port 1 = status {2'b0, tx_ovf, frame_err, rx_ovr, tx_idle, tx_full, rx_full, rx_empty}.
  - port 2 = D.
  - ports 3–7 read 0.
- Write map (`iowr`):
  - port 0 pushes `data_out[7:0]` to the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
  - port 1: a 1 in bit 4/5/6 clears rx_ovr/frame_err/tx_ovf respectively.
  - port 2 loads D. Values below 3 are stored but used as 3.
  - ports 3–7 are ignored.
- Sticky flag set and clear in the same cycle: set wins.
- tx_idle = TX FIFO empty and TX shifter idle.
- TX FSM states:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shifter and go to START.
  - START: `txd`=0, 1 bit period.
  - DATA: 8 bits, LSB first.
  - STOP: `txd`=1, 1 bit period. Then back to IDLE, which reloads the same cycle if the FIFO is non-empty, so back-to-back frames have no gap.
- RX input: `rxd` passes a 2-flop synchroniser; all RX decisions use the synchronised value.
- RX FSM states:
  - IDLE: wait for low.
  - START: count D>>1 clocks. If still low, go to DATA; if high, treat as a glitch and return to IDLE.
  - DATA: sample every D+1 clocks, 8 bits LSB first.
  - STOP: sample after D+1 clocks.
    - Stop=1: push the byte. If the RX FIFO is full, drop it and set rx_ovr.
    - Stop=0: set frame_err, no push, go to BREAK.
  - BREAK: wait for synchronised `rxd`=1, then IDLE.
- An RX push and a port-0 pop in the same cycle on a full FIFO both succeed, with no overrun.
- A TX push and a TX-engine pop in the same cycle on a full FIFO both succeed, with no tx_ovf.
- FIFO pointers are FIFO_AW+1 bits wide and wrap modulo 2·depth. Full when the MSBs differ and the rest are equal.
- Bit counters are 9-bit down-counters reloaded with the effective D. A D write mid-frame takes effect at the next reload; the current bit is unaffected.

## Timing
- Reset (asynchronous assert) sets:
  - `txd`=1, D=DIV_INIT;
  - both FIFOs empty, all flags 0;
  - both FSMs in IDLE;
  - synchroniser flops at 1;
  - `data_in`=0.
- Reset mid-frame truncates the frame: `txd` goes high immediately.
- Release is synchronous to the next `clk` edge.
- Read latency: zero. `data_in` is valid in the same cycle as `iord`, and side effects (pop) happen at the closing edge.
- TX latency:
  - `iowr` to port 0 in cycle N with TX idle: FIFO non-empty after edge N, shifter loaded at edge N+1.
  - `txd` falls after edge N+1.
  - A frame lasts exactly 10·(D+1) clocks.
- RX latency:
  - The byte is visible (rx_empty=0) 2 sync cycles + (D>>1) + 9·(D+1) + 1 clocks after the `rxd` falling edge.
  - Data bits are sampled mid-bit.
- Flag and status reads reflect state as of the start of the cycle. Effects of a push/pop at an edge appear in the next cycle.

## Test plan
- Reset then read port 1 → 9'h009 (rx_empty, tx_idle). Read port 2 → 103. Read port 0 → 9'h100. `txd`=1.
- Write D=3, write 0x5A to port 0:
  - `txd` low 4 clocks starting the 2nd edge after `iowr`;
  - then bits 0,1,0,1,1,0,1,0, each 4 clocks;
  - then high 4 clocks.
  - tx_idle returns to 1 after 40 clocks.
- With D=3, write 6 bytes back-to-back:
  - 5 are transmitted, as 1 goes to the shifter and 4 to the FIFO, with no inter-frame gap;
  - the 6th is dropped and tx_ovf=1;
  - write port 1 with 9'h040 → tx_ovf=0.
- Drive 5 RX frames of 0xA3 at 4 clocks/bit with D=3:
  - the first 4 are readable as 9'h0A3;
  - rx_full=1 after the 4th;
  - the 5th sets rx_ovr.
  - Repeat with a port-0 read on the 5th push cycle: no rx_ovr, 4 entries remain.
- RX frame with stop bit 0 → frame_err=1, no push, and no restart until `rxd` returns high. A 1-clock low glitch on `rxd` → no frame, no flags.
- Assert `reset` mid-TX frame and mid-RX frame → `txd`=1 immediately. After release, both FSMs are idle and the FIFOs are empty.
